// File: rtl/seg7_pkg.sv
// Shared glyph constants, FSM state type and segment-to-hex decode for the
// seven-segment scan decoder.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Active-high glyph in, {valid, blank, code[3:0]} out; unknown glyphs give code F.
    function automatic logic [5:0] seg_to_hex(input logic [6:0] seg);
        logic [5:0] res;
        case (seg)
            SEG_0:     res = {1'b1, 1'b0, 4'h0};
            SEG_1:     res = {1'b1, 1'b0, 4'h1};
            SEG_2:     res = {1'b1, 1'b0, 4'h2};
            SEG_3:     res = {1'b1, 1'b0, 4'h3};
            SEG_4:     res = {1'b1, 1'b0, 4'h4};
            SEG_5:     res = {1'b1, 1'b0, 4'h5};
            SEG_6:     res = {1'b1, 1'b0, 4'h6};
            SEG_7:     res = {1'b1, 1'b0, 4'h7};
            SEG_8:     res = {1'b1, 1'b0, 4'h8};
            SEG_9:     res = {1'b1, 1'b0, 4'h9};
            SEG_A:     res = {1'b1, 1'b0, 4'hA};
            SEG_B:     res = {1'b1, 1'b0, 4'hB};
            SEG_C:     res = {1'b1, 1'b0, 4'hC};
            SEG_D:     res = {1'b1, 1'b0, 4'hD};
            SEG_E:     res = {1'b1, 1'b0, 4'hE};
            SEG_F:     res = {1'b1, 1'b0, 4'hF};
            SEG_BLANK: res = {1'b1, 1'b1, 4'h0};
            default:   res = {1'b0, 1'b0, 4'hF};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational decode of one active-high seven-segment glyph into its hex code.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic       blank,
    output logic [3:0] code
);

    logic [5:0] dec_s;

    assign dec_s = seg_to_hex(seg);
    assign valid = dec_s[5];
    assign blank = dec_s[4];
    assign code  = dec_s[3:0];

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers hex digit frames from a multiplexed, active-low seven-segment scan.
// Optional decimal-point capture is enabled with the SEG7_DP_EN macro.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NUM_DIGITS-1:0]   an_i,
    input  logic [6:0]              seg_i,
`ifdef SEG7_DP_EN
    input  logic                    dp_i,
    output logic [NUM_DIGITS-1:0]   dp_o,
`endif
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic [NUM_DIGITS-1:0]   blank_o,
    output logic                    frame_valid_o,
    output logic                    glyph_err_o,
    output logic                    multi_an_err_o
);

    localparam int         VW         = NUM_DIGITS + 8;
    localparam logic [7:0] SETTLE_LIM = 8'(SETTLE_CYCLES);

    logic                    dp_raw_s;
    logic [VW-1:0]           raw_s, sync1_r, sync2_r, prev_r;
    logic [NUM_DIGITS-1:0]   an_s, prev_an_s, onehot_s;
    logic [6:0]              seg_high_s;
    logic                    changed_s, idle_s, multi_s, done_s;
    logic [7:0]              cnt_r, cnt_n_s, cnt_base_s;
    state_t                  state_r, state_n_s, eval_state_s;
    logic                    eval_multi_s, multi_set_s, sample_s;
    logic                    dec_valid_s, dec_blank_s;
    logic [3:0]              dec_code_s;
    logic [4*NUM_DIGITS-1:0] shadow_r, shadow_n_s, digits_r;
    logic [NUM_DIGITS-1:0]   shadow_blank_r, blank_n_s, blank_r;
    logic [NUM_DIGITS-1:0]   seen_r, seen_n_s;
    logic                    frame_valid_r, glyph_err_r, multi_err_r;

`ifdef SEG7_DP_EN
    assign dp_raw_s = dp_i;
`else
    assign dp_raw_s = 1'b1;
`endif

    // The decimal point rides along in the same vector so it joins the stability check.
    assign raw_s = {dp_raw_s, seg_i, an_i};

    // Two-flop synchronizer plus a one-cycle-old copy for change detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_r <= {VW{1'b1}};
            sync2_r <= {VW{1'b1}};
            prev_r  <= {VW{1'b1}};
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign an_s       = sync2_r[NUM_DIGITS-1:0];
    assign prev_an_s  = prev_r[NUM_DIGITS-1:0];
    assign seg_high_s = ~prev_r[NUM_DIGITS +: 7];
    assign onehot_s   = ~prev_an_s;
    assign changed_s  = (sync2_r != prev_r);
    assign idle_s     = &an_s;
    assign multi_s    = ($countones(~an_s) > 1);
    assign sample_s   = (state_r == SAMPLE);

    // Count of consecutive cycles the current value has been present, first cycle = 1.
    assign cnt_base_s = changed_s ? 8'd1 : ((cnt_r == 8'hFF) ? cnt_r : cnt_r + 8'd1);
    assign done_s     = (cnt_base_s >= SETTLE_LIM);

    // Where an active (non-idle) strobe leads once its stable count is known.
    always_comb begin
        eval_state_s = SETTLE;
        eval_multi_s = 1'b0;
        if (!done_s) begin
            eval_state_s = SETTLE;
            eval_multi_s = 1'b0;
        end else if (multi_s) begin
            eval_state_s = HOLD;
            eval_multi_s = 1'b1;
        end else begin
            eval_state_s = SAMPLE;
            eval_multi_s = 1'b0;
        end
    end

    // Next-state and settle-count logic.
    always_comb begin
        state_n_s   = state_r;
        cnt_n_s     = cnt_r;
        multi_set_s = 1'b0;
        case (state_r)
            WAIT, SETTLE: begin
                if (idle_s) begin
                    state_n_s = WAIT;
                    cnt_n_s   = 8'd0;
                end else begin
                    state_n_s   = eval_state_s;
                    cnt_n_s     = cnt_base_s;
                    multi_set_s = eval_multi_s;
                end
            end
            SAMPLE, HOLD: begin
                if (!changed_s) begin
                    state_n_s = HOLD;
                end else if (idle_s) begin
                    state_n_s = WAIT;
                    cnt_n_s   = 8'd0;
                end else begin
                    state_n_s   = eval_state_s;
                    cnt_n_s     = cnt_base_s;
                    multi_set_s = eval_multi_s;
                end
            end
            default: begin
                state_n_s = WAIT;
                cnt_n_s   = 8'd0;
            end
        endcase
    end

    // FSM state and settle counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= WAIT;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
        end
    end

    seg7_glyph_decode u_glyph_decode (
        .seg   (seg_high_s),
        .valid (dec_valid_s),
        .blank (dec_blank_s),
        .code  (dec_code_s)
    );

    // Shadow contents as they will stand after the current sample is written.
    always_comb begin
        shadow_n_s = shadow_r;
        blank_n_s  = shadow_blank_r;
        seen_n_s   = seen_r | onehot_s;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (onehot_s[k]) begin
                shadow_n_s[4*k +: 4] = dec_code_s;
                blank_n_s[k]         = dec_blank_s;
            end else begin
                shadow_n_s[4*k +: 4] = shadow_r[4*k +: 4];
                blank_n_s[k]         = shadow_blank_r[k];
            end
        end
    end

    // Shadow capture, frame publication and sticky error flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow_r       <= {(4*NUM_DIGITS){1'b0}};
            shadow_blank_r <= {NUM_DIGITS{1'b0}};
            seen_r         <= {NUM_DIGITS{1'b0}};
            digits_r       <= {(4*NUM_DIGITS){1'b0}};
            blank_r        <= {NUM_DIGITS{1'b1}};
            frame_valid_r  <= 1'b0;
            glyph_err_r    <= 1'b0;
            multi_err_r    <= 1'b0;
        end else begin
            frame_valid_r <= 1'b0;
            if (sample_s) begin
                shadow_r       <= shadow_n_s;
                shadow_blank_r <= blank_n_s;
                if (&seen_n_s) begin
                    digits_r      <= shadow_n_s;
                    blank_r       <= blank_n_s;
                    frame_valid_r <= 1'b1;
                    seen_r        <= {NUM_DIGITS{1'b0}};
                end else begin
                    seen_r <= seen_n_s;
                end
                if (!dec_valid_s) begin
                    glyph_err_r <= 1'b1;
                end else begin
                    glyph_err_r <= glyph_err_r;
                end
            end else begin
                seen_r <= seen_r;
            end
            if (multi_set_s) begin
                multi_err_r <= 1'b1;
            end else begin
                multi_err_r <= multi_err_r;
            end
        end
    end

`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0] dp_shadow_r, dp_shadow_n_s, dp_r;

    // Decimal point is stored lit-high per digit alongside the glyph code.
    always_comb begin
        dp_shadow_n_s = dp_shadow_r;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (onehot_s[k]) begin
                dp_shadow_n_s[k] = ~prev_r[VW-1];
            end else begin
                dp_shadow_n_s[k] = dp_shadow_r[k];
            end
        end
    end

    // Decimal-point shadow and published frame copy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dp_shadow_r <= {NUM_DIGITS{1'b0}};
            dp_r        <= {NUM_DIGITS{1'b0}};
        end else if (sample_s) begin
            dp_shadow_r <= dp_shadow_n_s;
            if (&seen_n_s) begin
                dp_r <= dp_shadow_n_s;
            end else begin
                dp_r <= dp_r;
            end
        end else begin
            dp_shadow_r <= dp_shadow_r;
        end
    end

    assign dp_o = dp_r;
`endif

    assign digits_o       = digits_r;
    assign blank_o        = blank_r;
    assign frame_valid_o  = frame_valid_r;
    assign glyph_err_o    = glyph_err_r;
    assign multi_an_err_o = multi_err_r;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scans plus random strobe runs
// checked against a run-level behavioural model.
module tb_seg7_scan_decoder;

    localparam int ND = 8;
    localparam int S  = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [31:0] digits_o;
    logic [7:0]  blank_o;
    logic        frame_valid_o, glyph_err_o, multi_an_err_o;
`ifdef SEG7_DP_EN
    logic [7:0]  dp_o;
`endif

    always #5 clk = ~clk;

    seg7_scan_decoder #(.NUM_DIGITS(ND), .SETTLE_CYCLES(S)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .an_i           (an),
        .seg_i          (seg),
`ifdef SEG7_DP_EN
        .dp_i           (dp),
        .dp_o           (dp_o),
`endif
        .digits_o       (digits_o),
        .blank_o        (blank_o),
        .frame_valid_o  (frame_valid_o),
        .glyph_err_o    (glyph_err_o),
        .multi_an_err_o (multi_an_err_o)
    );

    // Active-high glyph table, index = hex value.
    logic [6:0] glyph_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                     7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: what the display must show, derived run by run.
    logic [31:0] m_shadow;
    logic [7:0]  m_blank_sh, m_seen;
    logic        m_gerr, m_merr;
    logic [39:0] exp_q [$];
    logic [31:0] cur_d;
    logic [7:0]  cur_b;
    logic [7:0]  prev_an;
    logic [6:0]  prev_seg;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          pulses   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_shadow   = 32'h0;
        m_blank_sh = 8'h00;
        m_seen     = 8'h00;
        m_gerr     = 1'b0;
        m_merr     = 1'b0;
        exp_q.delete();
        cur_d      = 32'h0;
        cur_b      = 8'hFF;
        prev_an    = 8'hFF;
        prev_seg   = 7'h7F;
    endtask

    // A run of n identical cycles is sampled iff it lasts at least S cycles.
    task automatic model_run(input logic [7:0] a, input logic [6:0] s_low, input int n);
        logic [6:0] hi;
        logic [3:0] code;
        logic       blk, err;
        int         k;
        if (n >= S && a != 8'hFF) begin
            if ($countones(~a) > 1) begin
                m_merr = 1'b1;
            end else begin
                hi = ~s_low;
                k = 0;
                for (int i = 0; i < 8; i++) if (!a[i]) k = i;
                blk = (hi == 7'h00);
                err = !blk;
                code = blk ? 4'h0 : 4'hF;
                for (int i = 0; i < 16; i++) begin
                    if (glyph_tab[i] == hi) begin
                        code = 4'(i);
                        err = 1'b0;
                    end
                end
                if (err) m_gerr = 1'b1;
                m_shadow[4*k +: 4] = code;
                m_blank_sh[k]      = blk;
                m_seen[k]          = 1'b1;
                if (&m_seen) begin
                    exp_q.push_back({m_blank_sh, m_shadow});
                    m_seen = 8'h00;
                end
            end
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [6:0] s_low, input int n);
        logic [6:0] sx;
        sx = s_low;
        if (a == prev_an && sx == prev_seg) sx = sx ^ 7'h01;
        an  = a;
        seg = sx;
        model_run(a, sx, n);
        prev_an  = a;
        prev_seg = sx;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        drive(8'hFF, 7'h7F, n);
    endtask

    task automatic scan_digit(input int k, input int code, input int n);
        logic [7:0] a;
        a = ~(8'h01 << k);
        drive(a, ~glyph_tab[code], n);
    endtask

    task automatic check_flags(input string name);
        check({name, "_glyph_err"}, glyph_err_o, m_gerr);
        check({name, "_multi_err"}, multi_an_err_o, m_merr);
    endtask

    // Per-cycle comparison of the published frame against the model.
    always @(negedge clk) begin
        if (!rstn) begin
            check("rst_digits", digits_o, 32'h0);
            check("rst_blank", blank_o, 8'hFF);
            check("rst_frame_valid", frame_valid_o, 1'b0);
            check("rst_glyph_err", glyph_err_o, 1'b0);
            check("rst_multi_err", multi_an_err_o, 1'b0);
        end else if (frame_valid_o) begin
            pulses++;
            check("frame_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                {cur_b, cur_d} = exp_q.pop_front();
                check("frame_digits", digits_o, cur_d);
                check("frame_blank", blank_o, cur_b);
            end
        end else begin
            check("hold_digits", digits_o, cur_d);
            check("hold_blank", blank_o, cur_b);
        end
    end

    initial begin
        int p0;
        int order [8] = '{7, 5, 3, 1, 0, 2, 4, 6};
        logic [7:0] a;
        logic [6:0] s;
        int r, d, e;

        rstn = 1'b0;
        dp   = 1'b1;
        an   = 8'hFF;
        seg  = 7'h7F;
        model_reset();

        // Reset held with toggling inputs.
        repeat (10) begin
            @(posedge clk);
            #1;
            an  = 8'($urandom);
            seg = 7'($urandom);
        end
        an  = 8'hFF;
        seg = 7'h7F;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(3);

        // Plain scan, codes 1..8.
        p0 = pulses;
        for (int k = 0; k < 8; k++) scan_digit(k, k + 1, 20);
        idle(12);
        check("scan_digits", digits_o, 32'h87654321);
        check("scan_blank", blank_o, 8'h00);
        check("scan_pulses", pulses - p0, 1);
        check_flags("scan");

        // Settle boundary: 3-cycle runs must not sample, 8-cycle run must.
        p0 = pulses;
        for (int i = 0; i < 7; i++) drive(8'hFE, ~glyph_tab[(i % 2 == 1) ? 8 : 3], 3);
        drive(8'hFE, ~glyph_tab[8], 8);
        for (int k = 1; k < 8; k++) scan_digit(k, k, 20);
        idle(12);
        check("settle_digits", digits_o, 32'h76543218);
        check("settle_pulses", pulses - p0, 1);

        // Out-of-order scan with digit 5 blank.
        p0 = pulses;
        for (int i = 0; i < 8; i++) begin
            if (order[i] == 5) drive(8'hDF, 7'h7F, 20);
            else scan_digit(order[i], order[i], 20);
        end
        idle(12);
        check("blank_digits", digits_o, 32'h76043210);
        check("blank_blank", blank_o, 8'h20);
        check("blank_pulses", pulses - p0, 1);

        // Two anodes active and stable.
        p0 = pulses;
        drive(8'hFC, ~glyph_tab[1], 10);
        idle(12);
        check("multi_err", multi_an_err_o, 1'b1);
        check("multi_pulses", pulses - p0, 0);
        check_flags("multi");

        // Unknown glyph on digit 3, then a good frame: error stays set.
        for (int k = 0; k < 8; k++) begin
            if (k == 3) drive(8'hF7, 7'h7E, 20);
            else scan_digit(k, k, 20);
        end
        idle(12);
        check("glyph_digits", digits_o, 32'h7654F210);
        check("glyph_err", glyph_err_o, 1'b1);
        for (int k = 0; k < 8; k++) scan_digit(k, k, 20);
        idle(12);
        check("glyph_good_digits", digits_o, 32'h76543210);
        check("glyph_err_sticky", glyph_err_o, 1'b1);

        // Reset after half a frame; the next frame needs all 8 digits again.
        for (int k = 0; k < 4; k++) scan_digit(k, 9, 20);
        idle(12);
        rstn = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(3);
        p0 = pulses;
        for (int k = 0; k < 8; k++) scan_digit(k, k + 8, 20);
        idle(12);
        check("reset_digits", digits_o, 32'hFEDCBA98);
        check("reset_pulses", pulses - p0, 1);
        check_flags("reset");

        // Random strobe runs.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            d = $urandom_range(0, 7);
            if (r < 20) begin
                a = 8'hFF;
            end else if (r < 26) begin
                e = (d + $urandom_range(1, 7)) % 8;
                a = ~((8'h01 << d) | (8'h01 << e));
            end else begin
                a = ~(8'h01 << d);
            end
            r = $urandom_range(0, 99);
            if (r < 5) s = 7'($urandom);
            else if (r < 12) s = 7'h7F;
            else s = ~glyph_tab[$urandom_range(0, 15)];
            drive(a, s, $urandom_range(1, 9));
        end
        idle(20);
        check("random_pending", exp_q.size(), 0);
        check_flags("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the board's multiplexed 7-segment display driver.
- Samples the anode strobes (AN) and the active-low segment lines (CA..CG), waits for each strobe to settle, and decodes the glyph back to a 4-bit hex code per digit.
- Assembles a full 8-digit frame and flags it valid.
- Sits in the verification/monitor path beside the display outputs. It is synthesizable, so it can also loop back on-chip for self-check.

Parameters:
- NUM_DIGITS, 8: number of anode positions scanned.
- SETTLE_CYCLES, 4: consecutive identical cycles of (an_i, seg_i) required before a sample is taken; range 1..255.

Ports:
- clk  in  1  system clock, 100 MHz domain.
- rstn  in  1  asynchronous, active-low reset.
- an_i  in  NUM_DIGITS  anode strobes, active-low; bit k selects digit k.
- seg_i  in  7  segments, active-low; bit0=CA(a) ... bit6=CG(g).
- digits_o  out  4*NUM_DIGITS  last complete frame; digit k at [4k+3:4k].
- blank_o  out  NUM_DIGITS  digit k was all-segments-off in last frame.
- frame_valid_o  out  1  one-cycle pulse when digits_o/blank_o update.
- glyph_err_o  out  1  sticky: unknown segment pattern sampled.
- multi_an_err_o  out  1  sticky: more than one anode active while stable.

Behaviour:
- Reset (rstn low, async): digits_o=0, blank_o=all ones, frame_valid_o=0, both error flags=0, seen mask=0, settle count=0, FSM=WAIT.
- Reset release mid-scan: operation restarts cleanly.
- Input registering:
  - an_i and seg_i pass through a 2-flop synchronizer first, adding 2 cycles of latency.
  - All comparisons below use the synchronized values.
- FSM states:
  - WAIT: no anode active (an == all ones). Settle count is held at 0.
  - SETTLE: exactly one anode active. The count increments while (an, seg) equals the previous cycle's value; any change reloads the count to 1.
  - When the count reaches SETTLE_CYCLES, the FSM takes a SAMPLE (one cycle), then goes to HOLD.
  - HOLD: stays until (an, seg) changes. A change to another single anode goes to SETTLE; a change to all-off goes to WAIT.
  - A long strobe is sampled exactly once.
- Multiple anodes active:
  - More than one anode low for SETTLE_CYCLES stable cycles sets multi_an_err_o.
  - No sample is taken; the FSM goes to HOLD.
- Decode (active-high form, bit0=a):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F.
  - 00 → blank: code 0, blank bit set.
  - Any other pattern → code F, blank bit clear, glyph_err_o set.
- Frame assembly:
  - On SAMPLE of digit k, the shadow code, shadow blank bit and seen[k] are written. Resampling an already-seen digit overwrites its shadow value.
  - When seen becomes all ones, the cycle after the SAMPLE: digits_o and blank_o load from the shadow, frame_valid_o pulses high for 1 cycle, and seen clears.
  - The shadow keeps its values.
- Scan order does not matter. Digits that are never strobed block frame_valid_o indefinitely; there is no timeout.
- Error flags clear only on reset.

Optional Feature:
- Macro: SEG7_DP_EN.
- Defined:
  - Adds input dp_i (1 bit, active-low, the CP/DP line) and output dp_o (NUM_DIGITS bits, reset 0).
  - dp_i is synchronized and included in the stability comparison.
  - Its value is captured per digit and presented on dp_o with frame_valid_o.
- Undefined: the ports are absent and the decimal point is ignored.

Decomposition:
- Package seg7_pkg:
  - Decode-table constants SEG_0..SEG_F and SEG_BLANK (7-bit, active-high).
  - typedef state_t {WAIT, SETTLE, SAMPLE, HOLD}.
  - Function seg_to_hex returning {valid, blank, code[3:0]}.
- One natural sub-module: seg7_glyph_decode, combinational 7-bit → {valid, blank, code}. The FSM, synchronizer and frame shadow stay in seg7_scan_decoder.

Test Plan:
- Reset: hold rstn=0, toggle inputs → digits_o=0, blank_o=8'hFF, no frame_valid_o pulse. Release, then scan digits 0..7 with codes 1..8, 20 cycles each → exactly one frame_valid_o pulse; digits_o=32'h87654321, blank_o=0.
- Settle boundary, SETTLE_CYCLES=4: an_i=8'hFE, seg_i toggles between the 3 and 8 patterns every 3 cycles → no sample taken. Then hold 8 stable → exactly one sample with code 8.
- Unknown glyph: digit 3 strobed with active-low seg 7'h7E (a only) → digit 3 code F, glyph_err_o=1 after SAMPLE; it stays 1 through later good frames.
- Blank and out-of-order scan: order 7,5,3,1,0,2,4,6, digit 5 all-off → frame_valid_o pulse once; blank_o=8'h20.
- Multi-anode: an_i=8'hFC stable 10 cycles → multi_an_err_o=1; seen unchanged; no frame_valid_o pulse.
- Mid-frame reset: after 4 digits sampled, pulse rstn low 1 cycle, then a full scan → frame_valid_o only after all 8 digits rescanned; digits_o reflects the post-reset values.
